// File: rtl/mdu_sequencer_pkg.sv
// Shared types and helpers for the RV64M multiply/divide sequencer.
// Operand width is XLEN; W ops work on the low WLEN bits.
package mdu_sequencer_pkg;

    localparam int XLEN = 64;
    localparam int WLEN = 32;

    typedef enum logic [3:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
    } mdu_op_t;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} mdu_state_t;

    function automatic logic is_w_op(mdu_op_t op);
        return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    endfunction

    // Signedness of rs1; rs2 is signed for the same ops except MULHSU.
    function automatic logic is_signed_op(mdu_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_MULW, OP_DIVW, OP_REMW};
    endfunction

    function automatic logic is_mul_op(mdu_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW};
    endfunction

    function automatic logic is_rem_op(mdu_op_t op);
        return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    endfunction

    function automatic logic [XLEN-1:0] w_fix(logic w, logic [XLEN-1:0] r);
        return w ? {{(XLEN-WLEN){r[WLEN-1]}}, r[WLEN-1:0]} : r;
    endfunction

    function automatic logic [XLEN-1:0] mul_pick(mdu_op_t op, logic neg, logic [2*XLEN-1:0] prod);
        logic [2*XLEN-1:0] p;
        p = neg ? -prod : prod;
        if (op inside {OP_MULH, OP_MULHSU, OP_MULHU}) return p[2*XLEN-1:XLEN];
        return w_fix(is_w_op(op), p[XLEN-1:0]);
    endfunction

    function automatic logic [XLEN-1:0] div_pick(mdu_op_t op, logic neg,
                                                 logic [XLEN-1:0] quot, logic [XLEN-1:0] rem);
        logic [XLEN-1:0] r;
        r = is_rem_op(op) ? rem : quot;
        r = neg ? -r : r;
        return w_fix(is_w_op(op), r);
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Execute-stage <-> MDU handshake: op issue, flush/ack control, stall and result return.
interface mdu_sequencer_if;
    import mdu_sequencer_pkg::*;

    logic            valid_i;
    mdu_op_t         op_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            ack_i;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (output valid_i, op_i, a_i, b_i, flush_i, ack_i,
                    input  stall_o, done_o, result_o);
    modport slave  (input  valid_i, op_i, a_i, b_i, flush_i, ack_i,
                    output stall_o, done_o, result_o);
endinterface

// File: rtl/mdu_divider.sv
// Restoring divider on unsigned magnitudes, one quotient bit per step_i.
// W ops preload the dividend into the upper half so 32 steps suffice.
module mdu_divider
    import mdu_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            step_i,
    input  logic            w_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quot_nxt_o,
    output logic [XLEN-1:0] rem_nxt_o
);
    logic [XLEN-1:0] rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
    logic [XLEN:0]   rem_sh, diff;

    always_comb begin
        // Partial remainder stays below the divisor, so one extra bit holds the shift.
        rem_sh     = {rem_q, quot_q[XLEN-1]};
        diff       = rem_sh - {1'b0, dvsr_q};
        quot_nxt_o = {quot_q[XLEN-2:0], ~diff[XLEN]};
        rem_nxt_o  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];

        rem_d  = rem_q;
        quot_d = quot_q;
        dvsr_d = dvsr_q;
        if (start_i) begin
            rem_d  = '0;
            quot_d = w_i ? {dividend_i[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : dividend_i;
            dvsr_d = divisor_i;
        end else if (step_i) begin
            rem_d  = rem_nxt_o;
            quot_d = quot_nxt_o;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvsr_q <= '0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvsr_q <= dvsr_d;
        end
    end
endmodule

// File: rtl/mdu_sequencer.sv
// RV64M multi-cycle multiply/divide controller: shift-add multiplier here, restoring divider below.
// Define MDU_FAST_MUL_EN to compute MUL* ops in one cycle with the `*` operator.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    mdu_sequencer_if.slave io
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    mdu_state_t          state_q, state_d;
    mdu_op_t             op_q, op_d;
    logic                neg_q, neg_d, done_q, done_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   mcand_q, mcand_d, acc_q, acc_d, acc_nxt;
    logic [XLEN-1:0]     mplier_q, mplier_d, result_q, result_d;

    logic                w_op, a_sgn, b_sgn, a_neg, b_neg, res_neg, div_zero, div_ovf;
    logic [XLEN-1:0]     a_ext, b_ext, a_mag, b_mag, min_val, special_raw, special_res;
    logic                div_start, div_step;
    logic [XLEN-1:0]     quot_nxt, rem_nxt;

    // Operand preparation for the op presented this cycle.
    always_comb begin
        w_op     = is_w_op(io.op_i);
        a_sgn    = is_signed_op(io.op_i);
        b_sgn    = a_sgn && (io.op_i != OP_MULHSU);
        a_ext    = w_op ? {{(XLEN-WLEN){a_sgn & io.a_i[WLEN-1]}}, io.a_i[WLEN-1:0]} : io.a_i;
        b_ext    = w_op ? {{(XLEN-WLEN){b_sgn & io.b_i[WLEN-1]}}, io.b_i[WLEN-1:0]} : io.b_i;
        a_neg    = a_sgn & a_ext[XLEN-1];
        b_neg    = b_sgn & b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        res_neg  = is_rem_op(io.op_i) ? a_neg : (a_neg ^ b_neg);
        min_val  = w_op ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (b_ext == '0);
        div_ovf  = a_sgn && (a_ext == min_val) && (b_ext == '1);
        if (div_zero) special_raw = is_rem_op(io.op_i) ? a_ext : '1;
        else          special_raw = is_rem_op(io.op_i) ? '0 : a_ext;
        special_res = w_fix(w_op, special_raw);
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_d     = neg_q;
        done_d    = done_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        result_d  = result_q;
        div_start = 1'b0;
        div_step  = 1'b0;
        acc_nxt   = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            ST_IDLE: if (io.valid_i) begin
                op_d  = io.op_i;
                neg_d = res_neg;
                cnt_d = w_op ? CNT_W'(WLEN) : CNT_W'(XLEN);
                if (is_mul_op(io.op_i)) begin
`ifdef MDU_FAST_MUL_EN
                    result_d = mul_pick(io.op_i, res_neg, {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag});
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
`else
                    mcand_d  = {{XLEN{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    state_d  = ST_MUL;
`endif
                end else if (div_zero || div_ovf) begin
                    result_d = special_res;
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                end else begin
                    div_start = 1'b1;
                    state_d   = ST_DIV;
                end
            end
            ST_MUL: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    result_d = mul_pick(op_q, neg_q, acc_nxt);
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                end
            end
            ST_DIV: begin
                div_step = 1'b1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    result_d = div_pick(op_q, neg_q, quot_nxt, rem_nxt);
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                end
            end
            ST_DONE: if (io.ack_i) begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // A squash wins over everything, including an op arriving in IDLE.
        if (io.flush_i) begin
            state_d   = ST_IDLE;
            done_d    = 1'b0;
            div_start = 1'b0;
            div_step  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    mdu_divider u_div (
        .clk        (clk),
        .reset      (reset),
        .start_i    (div_start),
        .step_i     (div_step),
        .w_i        (w_op),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .quot_nxt_o (quot_nxt),
        .rem_nxt_o  (rem_nxt)
    );

    assign io.stall_o  = io.valid_i & ~done_q;
    assign io.done_o   = done_q;
    assign io.result_o = result_q;

    // The execute stage must keep the op presented until done or squashed.
    a_valid_held: assert property (@(posedge clk) disable iff (reset)
        ((state_q == ST_MUL || state_q == ST_DIV) && !io.flush_i) |-> io.valid_i);
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: vector table plus flush/reset/hold sequences.
module tb_mdu_sequencer;
    import mdu_sequencer_pkg::*;

    typedef struct {
        mdu_op_t         op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        int              lat;
        bit              mul;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_pass = 0;

    mdu_sequencer_if bus ();
    mdu_sequencer dut (.clk(clk), .reset(reset), .io(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    endtask

    task automatic run_op(input mdu_op_t op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          output int lat, output logic [XLEN-1:0] res);
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        #1;
        chk("stall_busy", 64'(bus.stall_o), 64'd1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.done_o && lat < 200);
        res = bus.result_o;
    endtask

    task automatic ack_op();
        bus.ack_i = 1'b1;
        @(posedge clk); #1;
        bus.ack_i   = 1'b0;
        bus.valid_i = 1'b0;
    endtask

    task automatic count_done(input int n, output int hits);
        hits = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (bus.done_o) hits++;
        end
    endtask

    function automatic int mul_lat(input int base, input bit mul);
`ifdef MDU_FAST_MUL_EN
        if (mul) return 1;
`endif
        return mul ? base : base;
    endfunction

    initial begin
        vec_t            v[18];
        int              lat, hits;
        logic [XLEN-1:0] res;

        v[0]  = '{OP_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b0};
        v[1]  = '{OP_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0};
        v[2]  = '{OP_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b1};
        v[3]  = '{OP_MUL,    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                   65, 1'b1};
        v[4]  = '{OP_DIVU,   64'd5,                   64'd0,                   64'hFFFF_FFFF_FFFF_FFFF, 1,  1'b0};
        v[5]  = '{OP_REMU,   64'd5,                   64'd0,                   64'd5,                   1,  1'b0};
        v[6]  = '{OP_DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1,  1'b0};
        v[7]  = '{OP_REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                   1,  1'b0};
        v[8]  = '{OP_DIVW,   64'h0000_0000_8000_0000, 64'd1,                   64'hFFFF_FFFF_8000_0000, 33, 1'b0};
        v[9]  = '{OP_MULH,   64'hFFFF_FFFF_FFFF_FFFD, 64'd5,                   64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b1};
        v[10] = '{OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b1};
        v[11] = '{OP_MULW,   64'h0000_0001_0000_0003, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1'b1};
        v[12] = '{OP_REMUW,  64'hFFFF_FFFF_FFFF_FFF7, 64'h10,                  64'd7,                   33, 1'b0};
        v[13] = '{OP_DIVUW,  64'h0000_0000_FFFF_FFFE, 64'd1,                   64'hFFFF_FFFF_FFFF_FFFE, 33, 1'b0};
        v[14] = '{OP_REMW,   64'hFFFF_FFFF_FFFF_FFF9, 64'd3,                   64'hFFFF_FFFF_FFFF_FFFF, 33, 1'b0};
        v[15] = '{OP_DIVW,   64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1,  1'b0};
        v[16] = '{OP_MULHU,  64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd1,                   65, 1'b1};
        v[17] = '{OP_MUL,    64'h1234,                64'h10,                  64'h12340,               65, 1'b1};

        bus.valid_i = 1'b0;
        bus.op_i    = OP_MUL;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.flush_i = 1'b0;
        bus.ack_i   = 1'b0;
        reset       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done",   64'(bus.done_o),  64'd0);
        chk("rst_stall",  64'(bus.stall_o), 64'd0);
        chk("rst_result", bus.result_o,     64'd0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, lat, res);
            chk($sformatf("lat_%0d", i), 64'(lat), 64'(mul_lat(v[i].lat, v[i].mul)));
            chk($sformatf("res_%0d", i), res, v[i].exp);
            ack_op();
            chk($sformatf("ack_%0d", i), 64'(bus.done_o), 64'd0);
        end

        // Result held in DONE while the pipeline stalls elsewhere; valid stays high.
        run_op(OP_DIVU, 64'd100, 64'd7, lat, res);
        chk("hold_res0", res, 64'd14);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hold_done_%0d", k),  64'(bus.done_o),  64'd1);
            chk($sformatf("hold_res_%0d", k),   bus.result_o,     64'd14);
            chk($sformatf("hold_stall_%0d", k), 64'(bus.stall_o), 64'd0);
        end
        ack_op();
        chk("hold_ack", 64'(bus.done_o), 64'd0);

        // Flush ten cycles into a divide.
        bus.valid_i = 1'b1; bus.op_i = OP_DIVU; bus.a_i = 64'd100; bus.b_i = 64'd7;
        repeat (10) @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        #1;
        chk("flush_stall", 64'(bus.stall_o), 64'd0);
        chk("flush_done",  64'(bus.done_o),  64'd0);
        count_done(70, hits);
        chk("flush_no_done", 64'(hits), 64'd0);
        run_op(OP_MUL, 64'd6, 64'd7, lat, res);
        chk("flush_next_lat", 64'(lat), 64'(mul_lat(65, 1'b1)));
        chk("flush_next_res", res, 64'd42);
        ack_op();

        // Flush together with a new op in IDLE: the op is dropped.
        bus.valid_i = 1'b1; bus.op_i = OP_DIVU; bus.a_i = 64'd5; bus.b_i = 64'd0;
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        chk("flush_idle_done", 64'(bus.done_o), 64'd0);
        count_done(5, hits);
        chk("flush_idle_none", 64'(hits), 64'd0);

        // Reset ten cycles into a divide.
        bus.valid_i = 1'b1; bus.op_i = OP_DIV; bus.a_i = 64'd1000; bus.b_i = 64'd3;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset       = 1'b0;
        bus.valid_i = 1'b0;
        #1;
        chk("rst_mid_done",   64'(bus.done_o),  64'd0);
        chk("rst_mid_stall",  64'(bus.stall_o), 64'd0);
        chk("rst_mid_result", bus.result_o,     64'd0);
        count_done(70, hits);
        chk("rst_mid_no_done", 64'(hits), 64'd0);
        run_op(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat, res);
        chk("rst_next_lat", 64'(lat), 64'd65);
        chk("rst_next_res", res, 64'hFFFF_FFFF_FFFF_FFFD);
        ack_op();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
